// File: rtl/tetris_pkg.sv
// Shared constants and types for the Tetris board video/RAM slice:
// palette, background colour, board defaults and the arbiter FSM types.
package tetris_pkg;

    localparam int COLS_DEF = 10;
    localparam int ROWS_DEF = 20;

    // Pixel format is {b,g,r}, 4 bits each.
    localparam logic [11:0] BG_COLOR = 12'h000;

    // Entry 0 is the background so empty cells disappear into the border.
    localparam logic [15:0][11:0] PALETTE = {
        12'hF88, 12'h8F8, 12'h008, 12'h080,
        12'h800, 12'h444, 12'h888, 12'hFFF,
        12'h08F, 12'hFF0, 12'hF0F, 12'h0FF,
        12'hF00, 12'h0F0, 12'h00F, BG_COLOR
    };

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } vram_state_t;

    // Full FSM state, kept in one struct so it can be observed as a unit.
    typedef struct packed {
        vram_state_t state;
        logic [7:0]  clr_ptr;
    } vram_fsm_t;

endpackage

// File: rtl/board_ram.sv
// Single-port board RAM: synchronous read-first, one-cycle read latency,
// one 4-bit colour index per word. Contents are never reset.
module board_ram #(
    parameter int DEPTH = 200,
    parameter int AW    = 8,
    parameter int DW    = 4
) (
    input  logic          clk_25_175,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // One access per cycle: optional write plus registered read of the old word.
    always_ff @(posedge clk_25_175) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/board_vram_arbiter.sv
// Board VRAM arbiter: video scan-out owns the RAM inside the board window;
// outside it the clear engine or the game read/write ports get the RAM.
//
// Handshake: a requester raises req with addr/data and holds them stable
// until served. A write is served in the cycle wr_ack is high (RAM updated at
// the closing edge). A read is served when rd_valid pulses high for one
// cycle, one cycle after its grant, with rd_data valid only in that cycle.
// Dropping req before service cancels it with no side effects.
module board_vram_arbiter
    import tetris_pkg::*;
#(
    parameter int BOARD_X0   = 240,
    parameter int BOARD_Y0   = 80,
    parameter int CELL_SHIFT = 4,
    parameter int COLS       = COLS_DEF,
    parameter int ROWS       = ROWS_DEF
) (
    input  logic        clk_25_175,
    input  logic        reset,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    output logic [11:0] pixstream,
    input  logic        wr_req,
    input  logic [7:0]  wr_addr,
    input  logic [3:0]  wr_data,
    output logic        wr_ack,
    input  logic        rd_req,
    input  logic [7:0]  rd_addr,
    output logic [3:0]  rd_data,
    output logic        rd_valid,
    input  logic        clear_req,
    output logic        busy,
    output logic        frame_start
);

    localparam int          DEPTH    = COLS * ROWS;
    localparam logic [10:0] X_LO     = 11'(BOARD_X0);
    localparam logic [10:0] X_HI     = 11'(BOARD_X0 + (COLS << CELL_SHIFT));
    localparam logic [10:0] Y_LO     = 11'(BOARD_Y0);
    localparam logic [10:0] Y_HI     = 11'(BOARD_Y0 + (ROWS << CELL_SHIFT));
    localparam logic [8:0]  DEPTH9   = 9'(DEPTH);
    localparam logic [7:0]  LAST_PTR = 8'(DEPTH - 1);

    vram_fsm_t   fsm_q, fsm_d;
    logic        in_window;
    logic [9:0]  hrel, vrel;
    logic [7:0]  video_addr;
    logic        game_ok, wr_cand, rd_cand, grant_wr, grant_rd;
    logic        wr_in_range, rd_in_range;
    logic        last_rd_q;
    logic        rd_valid_q, rd_oob_q;
    logic        win_q;
    logic [11:0] pix_q;
    logic        frame_q;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [3:0]  ram_wdata, ram_rdata;

    assign in_window = ({1'b0, hpos} >= X_LO) && ({1'b0, hpos} < X_HI) &&
                       ({1'b0, vpos} >= Y_LO) && ({1'b0, vpos} < Y_HI);
    assign hrel       = hpos - 10'(BOARD_X0);
    assign vrel       = vpos - 10'(BOARD_Y0);
    assign video_addr = 8'(((vrel >> CELL_SHIFT) * 10'(COLS)) + (hrel >> CELL_SHIFT));

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH9);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH9);

    // Game ports compete only outside the window, in IDLE, out of reset.
    // A read already granted is masked while its rd_valid is showing so the
    // still-held rd_req is not served twice.
    assign game_ok  = reset && !in_window && (fsm_q.state == ST_IDLE);
    assign wr_cand  = wr_req && game_ok;
    assign rd_cand  = rd_req && !rd_valid_q && game_ok;
    assign grant_wr = wr_cand && (!rd_cand || last_rd_q);
    assign grant_rd = rd_cand && (!wr_cand || !last_rd_q);

    assign wr_ack      = grant_wr;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = (rd_valid_q && !rd_oob_q) ? ram_rdata : 4'd0;
    assign busy        = (fsm_q.state == ST_CLEAR);
    assign pixstream   = pix_q;
    assign frame_start = frame_q;

    // FSM state register.
    always_ff @(posedge clk_25_175) begin
        if (!reset) begin
            fsm_q <= '{state: ST_IDLE, clr_ptr: 8'd0};
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next state: clear walks the board one cell per non-window cycle.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q.state)
            ST_IDLE: begin
                if (clear_req) begin
                    fsm_d.state   = ST_CLEAR;
                    fsm_d.clr_ptr = 8'd0;
                end
            end
            ST_CLEAR: begin
                if (!in_window) begin
                    if (fsm_q.clr_ptr == LAST_PTR) begin
                        fsm_d.state   = ST_IDLE;
                        fsm_d.clr_ptr = 8'd0;
                    end else begin
                        fsm_d.clr_ptr = fsm_q.clr_ptr + 8'd1;
                    end
                end
            end
            default: fsm_d.state = ST_IDLE;
        endcase
    end

    // RAM port mux: video, then clear, then the granted game access.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = 8'd0;
        ram_wdata = 4'd0;
        if (in_window) begin
            ram_en   = 1'b1;
            ram_addr = video_addr;
        end else if (fsm_q.state == ST_CLEAR) begin
            ram_en   = reset;
            ram_we   = reset;
            ram_addr = fsm_q.clr_ptr;
        end else if (grant_wr) begin
            ram_en    = wr_in_range;
            ram_we    = wr_in_range;
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
        end else if (grant_rd) begin
            ram_en   = rd_in_range;
            ram_addr = rd_addr;
        end
    end

    // Game-side registers: read completion and round-robin memory.
    always_ff @(posedge clk_25_175) begin
        if (!reset) begin
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
            last_rd_q  <= 1'b1;
        end else begin
            rd_valid_q <= grant_rd;
            rd_oob_q   <= grant_rd && !rd_in_range;
            if (grant_wr) begin
                last_rd_q <= 1'b0;
            end else if (grant_rd) begin
                last_rd_q <= 1'b1;
            end
        end
    end

    // Video pipeline: RAM read, then registered palette lookup; frame pulse.
    always_ff @(posedge clk_25_175) begin
        if (!reset) begin
            win_q   <= 1'b0;
            pix_q   <= 12'h000;
            frame_q <= 1'b0;
        end else begin
            win_q   <= in_window;
            pix_q   <= win_q ? PALETTE[ram_rdata] : BG_COLOR;
            frame_q <= (hpos == 10'd0) && (vpos == 10'd0);
        end
    end

    board_ram #(
        .DEPTH(DEPTH),
        .AW   (8),
        .DW   (4)
    ) u_board_ram (
        .clk_25_175(clk_25_175),
        .en        (ram_en),
        .we        (ram_we),
        .addr      (ram_addr),
        .wdata     (ram_wdata),
        .rdata     (ram_rdata)
    );

endmodule

// File: tb/tb_board_vram_arbiter.sv
// Bench for board_vram_arbiter: directed steps plus random fills/scans,
// checked against a cell-array model of the board and the palette.
module tb_board_vram_arbiter;
    import tetris_pkg::*;

    localparam int X0    = 240;
    localparam int Y0    = 80;
    localparam int CELL  = 16;
    localparam int NC    = 10;
    localparam int NR    = 20;
    localparam int DEPTH = NC * NR;

    logic        clk_25_175 = 1'b0;
    logic        reset;
    logic [9:0]  hpos, vpos;
    logic [11:0] pixstream;
    logic        wr_req, wr_ack, rd_req, rd_valid, clear_req, busy, frame_start;
    logic [7:0]  wr_addr, rd_addr;
    logic [3:0]  wr_data, rd_data;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  mem_model [DEPTH];
    logic [11:0] exp_q [$];

    board_vram_arbiter dut (
        .clk_25_175 (clk_25_175),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .pixstream  (pixstream),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .clear_req  (clear_req),
        .busy       (busy),
        .frame_start(frame_start)
    );

    // Clock / watchdog
    always #5 clk_25_175 = ~clk_25_175;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk_25_175);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic blank();
        hpos = 10'd700;
        vpos = 10'd10;
    endtask

    function automatic bit in_win(int h, int v);
        return (h >= X0) && (h < X0 + NC * CELL) && (v >= Y0) && (v < Y0 + NR * CELL);
    endfunction

    function automatic logic [11:0] exp_pixel(int h, int v);
        logic [3:0] idx;
        if (!in_win(h, v)) return BG_COLOR;
        idx = mem_model[((v - Y0) / CELL) * NC + (h - X0) / CELL];
        return PALETTE[idx];
    endfunction

    // Driver: write, waiting (bounded) for wr_ack; updates the model.
    task automatic game_write(input int addr, input logic [3:0] data);
        bit seen;
        seen    = 1'b0;
        wr_req  = 1'b1;
        wr_addr = 8'(addr);
        wr_data = data;
        for (int i = 0; i < 50 && !seen; i++) begin
            settle();
            if (wr_ack === 1'b1) seen = 1'b1;
            cyc();
        end
        wr_req = 1'b0;
        check("wr_ack_seen", 32'(seen), 32'(1));
        if (seen && addr < DEPTH) mem_model[addr] = data;
    endtask

    // Driver: read, waiting (bounded) for rd_valid, then compare data.
    task automatic read_check(input string tag, input int addr, input logic [3:0] exp);
        bit         ok;
        logic [3:0] d;
        ok      = 1'b0;
        d       = 4'd0;
        rd_req  = 1'b1;
        rd_addr = 8'(addr);
        for (int i = 0; i < 50 && !ok; i++) begin
            cyc();
            if (rd_valid === 1'b1) begin
                ok = 1'b1;
                d  = rd_data;
            end
        end
        rd_req = 1'b0;
        check({tag, "_valid"}, 32'(ok), 32'(1));
        if (ok) check(tag, 32'(d), 32'(exp));
    endtask

    task automatic read_all(input string tag);
        blank();
        for (int a = 0; a < DEPTH; a++) read_check(tag, a, mem_model[a]);
    endtask

    // Scoreboard: each presented position is due on pixstream two edges later.
    task automatic scan(input int h, input int v);
        logic [11:0] e;
        hpos = 10'(h);
        vpos = 10'(v);
        exp_q.push_back(exp_pixel(h, v));
        cyc();
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check("pixstream", 32'(pixstream), 32'(e));
        end
    endtask

    task automatic scan_flush();
        logic [11:0] e;
        while (exp_q.size() > 0) begin
            cyc();
            e = exp_q.pop_front();
            check("pixstream_tail", 32'(pixstream), 32'(e));
        end
    endtask

    initial begin
        int         nw;
        int         acks;
        int         guard;
        bit         early;
        bit         win;
        logic [3:0] d;

        blank();
        reset     = 1'b0;
        wr_req    = 1'b0;
        rd_req    = 1'b0;
        clear_req = 1'b0;
        wr_addr   = 8'd0;
        wr_data   = 4'd0;
        rd_addr   = 8'd0;
        repeat (3) cyc();

        // Reset state
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_wr_ack", 32'(wr_ack), 32'(0));
        check("rst_rd_valid", 32'(rd_valid), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));
        check("rst_frame_start", 32'(frame_start), 32'(0));
        check("rst_pixstream", 32'(pixstream), 32'(0));

        // Requests under reset are never served
        wr_req = 1'b1; rd_req = 1'b1; wr_addr = 8'd3; rd_addr = 8'd3;
        settle();
        check("rst_wr_ack_gated", 32'(wr_ack), 32'(0));
        cyc();
        check("rst_rd_valid_gated", 32'(rd_valid), 32'(0));
        wr_req = 1'b0; rd_req = 1'b0;
        reset = 1'b1;

        // Tie after reset: write first, then read returns the new data
        rd_req = 1'b1; rd_addr = 8'd3;
        wr_req = 1'b1; wr_addr = 8'd3; wr_data = 4'd7;
        settle();
        check("tie_wr_first", 32'(wr_ack), 32'(1));
        cyc();
        wr_req = 1'b0;
        mem_model[3] = 4'd7;
        check("tie_rd_waits", 32'(rd_valid), 32'(0));
        settle();
        check("tie_wr_ack_pulse", 32'(wr_ack), 32'(0));
        cyc();
        check("tie_rd_valid", 32'(rd_valid), 32'(1));
        check("tie_rd_data", 32'(rd_data), 32'(7));
        rd_req = 1'b0;
        cyc();
        check("tie_rd_valid_pulse", 32'(rd_valid), 32'(0));

        // Random fill and random readback
        for (int a = 0; a < DEPTH; a++) game_write(a, 4'($urandom_range(15, 0)));
        for (int i = 0; i < 12; i++) begin
            int a;
            a = $urandom_range(DEPTH - 1, 0);
            read_check("rd_rand", a, mem_model[a]);
        end

        // Round robin: last served was a read, so write wins; then read wins
        rd_req = 1'b1; rd_addr = 8'd20;
        wr_req = 1'b1; wr_addr = 8'd21; wr_data = 4'd11;
        settle();
        check("rr_after_read_wr", 32'(wr_ack), 32'(1));
        cyc();
        mem_model[21] = 4'd11;
        wr_addr = 8'd22; wr_data = 4'd12;
        settle();
        check("rr_after_write_no_wr", 32'(wr_ack), 32'(0));
        cyc();
        check("rr_after_write_rd_valid", 32'(rd_valid), 32'(1));
        check("rr_after_write_rd_data", 32'(rd_data), 32'(mem_model[20]));
        rd_req = 1'b0;
        settle();
        check("rr_wr_follows", 32'(wr_ack), 32'(1));
        cyc();
        wr_req = 1'b0;
        mem_model[22] = 4'd12;
        read_check("rr_rd22", 22, mem_model[22]);

        // Video: cell 0 = 5, window edges, random positions
        blank();
        game_write(0, 4'd5);
        scan(240, 80); scan(239, 80); scan(240, 80);
        scan(399, 80); scan(400, 80); scan(240, 399); scan(240, 400);
        scan(240, 79); scan(399, 399); scan(255, 95); scan(256, 96);
        for (int i = 0; i < 60; i++) scan($urandom_range(440, 200), $urandom_range(420, 60));
        scan_flush();

        // Write held inside the window is served only when hpos reaches 400
        vpos = 10'd100;
        early = 1'b0;
        d = ~mem_model[10];
        wr_req = 1'b1; wr_addr = 8'd10; wr_data = d;
        for (int h = 300; h < 400; h++) begin
            hpos = 10'(h);
            settle();
            if (wr_ack !== 1'b0) early = 1'b1;
            cyc();
        end
        check("win_no_ack", 32'(early), 32'(0));
        hpos = 10'd400;
        settle();
        check("win_exit_ack", 32'(wr_ack), 32'(1));
        cyc();
        wr_req = 1'b0;
        mem_model[10] = d;
        blank();
        read_check("win_rd10", 10, d);

        // Out-of-range addresses
        game_write(200, 4'd15);
        read_check("oob_rd255", 255, 4'd0);
        read_check("oob_rd200", 200, 4'd0);
        read_all("oob_ram_unchanged");

        // Clear of a board full of 9s with window stalls and game pressure
        for (int a = 0; a < DEPTH; a++) game_write(a, 4'd9);
        blank();
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        check("clear_busy_rise", 32'(busy), 32'(1));
        wr_req = 1'b1; wr_addr = 8'd7; wr_data = 4'd3;
        rd_req = 1'b1; rd_addr = 8'd7;
        nw = 0; acks = 0; guard = 0;
        while (busy === 1'b1 && guard < 2000) begin
            win = ($urandom_range(2, 0) == 0);
            hpos = win ? 10'($urandom_range(399, 240)) : 10'($urandom_range(700, 400));
            vpos = 10'd200;
            clear_req = (guard == 37);
            settle();
            if (wr_ack !== 1'b0) acks++;
            if (!win) nw++;
            cyc();
            if (rd_valid !== 1'b0) acks++;
            guard++;
        end
        wr_req = 1'b0; rd_req = 1'b0; clear_req = 1'b0;
        check("clear_done", 32'(busy), 32'(0));
        check("clear_nonwindow_cycles", 32'(nw), 32'(DEPTH));
        check("clear_no_game_ack", 32'(acks), 32'(0));
        for (int a = 0; a < DEPTH; a++) mem_model[a] = 4'd0;
        read_all("clear_zero");

        // Reset mid-clear when clr_ptr reaches 50
        for (int a = 0; a < DEPTH; a++) game_write(a, 4'($urandom_range(15, 1)));
        blank();
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        repeat (50) cyc();
        reset = 1'b0;
        cyc();
        check("abort_busy", 32'(busy), 32'(0));
        reset = 1'b1;
        for (int a = 0; a < 50; a++) mem_model[a] = 4'd0;
        read_all("abort_cells");

        // frame_start pulse
        hpos = 10'd0; vpos = 10'd0;
        cyc();
        check("frame_start_pulse", 32'(frame_start), 32'(1));
        hpos = 10'd1;
        cyc();
        check("frame_start_drop", 32'(frame_start), 32'(0));
        hpos = 10'd0; vpos = 10'd1;
        cyc();
        check("frame_start_line1", 32'(frame_start), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
